// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage state encoding and fetch defaults.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {BOOT, FETCH, SQUASH, HOLD, HALT} fetch_state_t;

   localparam word_t       PC_INIT_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_STEP_DEFAULT = 4;

   // Instruction addresses are word aligned; low byte-offset bits are dropped.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instruction, next-pc} pair while IF/ID is stalled.
module fetch_skid_buf
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  clear,
   input  word_t instr_in,
   input  word_t npc_in,
   output logic  valid,
   output word_t instr,
   output word_t npc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         npc   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         npc   <= npc_in;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, non-abortable imem requests, IF/ID write with skid
// buffering, redirect and halt handling.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t       PC_INIT = PC_INIT_DEFAULT,
   parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   input  logic        halt_i,
   output logic        ifid_wen_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_npc_o,
   output logic [31:0] pc_o
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        tgt_q, tgt_d;
   logic         halt_pend_q, halt_pend_d;

   word_t pc_inc;
   word_t redir_tgt;
   logic  buf_load, buf_clear, buf_valid;
   word_t buf_instr, buf_npc;

   assign pc_inc    = pc_q + word_t'(PC_STEP);
   assign redir_tgt = align_word(redirect_addr_i);
   assign pc_o      = pc_q;
   assign imemaddr  = pc_q;

   fetch_skid_buf u_skid (
      .clk      (CLK),
      .rst      (RST),
      .load     (buf_load),
      .clear    (buf_clear),
      .instr_in (imemload),
      .npc_in   (pc_inc),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .npc      (buf_npc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= BOOT;
         pc_q        <= PC_INIT;
         tgt_q       <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      halt_pend_d  = halt_pend_q;
      imemREN      = 1'b0;
      ifid_wen_o   = 1'b0;
      ifid_instr_o = '0;
      ifid_npc_o   = '0;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
            if (redirect_i) pc_d = redir_tgt;
            if (halt_i) state_d = HALT;
         end
         FETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               if (redirect_i) begin
                  pc_d = redir_tgt;
               end else if (halt_i || halt_pend_q) begin
                  state_d = HALT;
               end else begin
                  pc_d = pc_inc;
                  if (stall_i) begin
                     buf_load = 1'b1;
                     state_d  = HOLD;
                  end else begin
                     ifid_wen_o   = 1'b1;
                     ifid_instr_o = imemload;
                     ifid_npc_o   = pc_inc;
                  end
               end
            end else begin
               // The request cannot be withdrawn; remember the target until it returns.
               if (redirect_i) begin
                  tgt_d   = redir_tgt;
                  state_d = SQUASH;
               end
               if (halt_i) halt_pend_d = 1'b1;
            end
         end
         SQUASH: begin
            imemREN = 1'b1;
            if (redirect_i) tgt_d = redir_tgt;
            if (halt_i) halt_pend_d = 1'b1;
            if (ihit) begin
               pc_d    = redirect_i ? redir_tgt : tgt_q;
               state_d = (halt_pend_q || halt_i) ? HALT : FETCH;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               buf_clear = 1'b1;
               pc_d      = redir_tgt;
               state_d   = FETCH;
            end else if (halt_i) begin
               buf_clear = 1'b1;
               state_d   = HALT;
            end else if (!stall_i && buf_valid) begin
               ifid_wen_o   = 1'b1;
               ifid_instr_o = buf_instr;
               ifid_npc_o   = buf_npc;
               buf_clear    = 1'b1;
               state_d      = FETCH;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      // Reset takes effect only at the edge, so hold the external interface quiet meanwhile.
      if (RST) begin
         imemREN      = 1'b0;
         ifid_wen_o   = 1'b0;
         ifid_instr_o = '0;
         ifid_npc_o   = '0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_addr_i;
   logic        halt_i;
   logic        ifid_wen_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_npc_o;
   logic [31:0] pc_o;

   int checks = 0;
   int errors = 0;

   // Reference model: PC, lifecycle flags, pending redirect and a queue of parked words.
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   bit          m_started;
   bit          m_halted;
   bit          m_redir_pend;
   bit          m_halt_pend;
   logic [63:0] m_buf[$];

   logic        last_ren, last_wen;
   logic [31:0] last_addr, last_instr, last_npc;

   fetch_unit dut (
      .CLK             (CLK),
      .RST             (RST),
      .imemREN         (imemREN),
      .imemaddr        (imemaddr),
      .ihit            (ihit),
      .imemload        (imemload),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .halt_i          (halt_i),
      .ifid_wen_o      (ifid_wen_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_npc_o      (ifid_npc_o),
      .pc_o            (pc_o)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit hit, input logic [31:0] load, input bit stall,
                       input bit redir, input logic [31:0] raddr, input bit halt);
      bit          e_ren, e_wen;
      logic [31:0] e_instr, e_npc, tgt;
      RST             = rst;
      ihit            = hit;
      imemload        = load;
      stall_i         = stall;
      redirect_i      = redir;
      redirect_addr_i = raddr;
      halt_i          = halt;
      #3;
      tgt     = raddr & 32'hFFFF_FFFC;
      e_ren   = !rst && m_started && !m_halted && (m_buf.size() == 0);
      e_wen   = 1'b0;
      e_instr = '0;
      e_npc   = '0;
      if (!rst && m_started && !m_halted) begin
         if (m_buf.size() != 0) begin
            if (!redir && !halt && !stall) begin
               e_wen   = 1'b1;
               e_instr = m_buf[0][63:32];
               e_npc   = m_buf[0][31:0];
            end
         end else if (hit && !m_redir_pend && !m_halt_pend && !redir && !halt && !stall) begin
            e_wen   = 1'b1;
            e_instr = load;
            e_npc   = m_pc + 32'd4;
         end
      end
      last_ren   = imemREN;
      last_wen   = ifid_wen_o;
      last_addr  = imemaddr;
      last_instr = ifid_instr_o;
      last_npc   = ifid_npc_o;
      chk("ren", {31'd0, imemREN}, {31'd0, e_ren});
      if (e_ren) chk("addr", imemaddr, m_pc);
      chk("wen", {31'd0, ifid_wen_o}, {31'd0, e_wen});
      chk("instr", ifid_instr_o, e_instr);
      chk("npc", ifid_npc_o, e_npc);
      if (!rst) chk("pc", pc_o, m_pc);

      if (rst) begin
         m_pc = 32'h0; m_tgt = 32'h0; m_started = 0; m_halted = 0;
         m_redir_pend = 0; m_halt_pend = 0; m_buf.delete();
      end else if (!m_started) begin
         m_started = 1;
         if (redir) m_pc = tgt;
         if (halt) m_halted = 1;
      end else if (m_halted) begin
         // frozen
      end else if (m_buf.size() != 0) begin
         if (redir) begin
            m_buf.delete(); m_pc = tgt;
         end else if (halt) begin
            m_buf.delete(); m_halted = 1;
         end else if (!stall) begin
            m_buf.delete();
         end
      end else if (m_redir_pend) begin
         if (redir) m_tgt = tgt;
         if (halt) m_halt_pend = 1;
         if (hit) begin
            m_pc = m_tgt;
            m_redir_pend = 0;
            if (m_halt_pend) m_halted = 1;
         end
      end else if (hit) begin
         if (redir) m_pc = tgt;
         else if (halt || m_halt_pend) m_halted = 1;
         else begin
            if (stall) m_buf.push_back({load, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
         end
      end else begin
         if (redir) begin
            m_redir_pend = 1; m_tgt = tgt;
         end
         if (halt) m_halt_pend = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      m_pc = 'x;
      // Reset and boot
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("boot_ren", {31'd0, last_ren}, 32'd0);
      // Sequential fetch
      step(0, 1, mem(m_pc), 0, 0, 0, 0);
      chk("t1_addr0", last_addr, 32'h0);
      chk("t1_npc0", last_npc, 32'h4);
      step(0, 1, mem(m_pc), 0, 0, 0, 0);
      chk("t1_addr4", last_addr, 32'h4);
      // Stall on addr 8 for three cycles
      step(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
      chk("t2_addr8", last_addr, 32'h8);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("t2_hold_ren", {31'd0, last_ren}, 32'd0);
      step(0, 1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t2_instr", last_instr, 32'hDEAD_BEEF);
      chk("t2_npc", last_npc, 32'hC);
      step(0, 1, mem(m_pc), 0, 0, 0, 0);
      chk("t2_addrC", last_addr, 32'hC);
      // Redirect while request outstanding
      step(0, 0, 0, 0, 1, 32'h100, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t3_hold_addr", last_addr, 32'h10);
      step(0, 1, mem(32'h10), 0, 0, 0, 0);
      chk("t3_discard", {31'd0, last_wen}, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t3_new_addr", last_addr, 32'h100);
      // Redirect coincident with ihit, misaligned target
      step(0, 1, mem(m_pc), 0, 1, 32'h200, 0);
      step(0, 1, mem(m_pc), 0, 1, 32'h203, 0);
      chk("t4_addr200", last_addr, 32'h200);
      step(0, 1, mem(m_pc), 0, 1, 32'hFFFF_FFFC, 0);
      chk("t4_aligned", last_addr, 32'h200);
      // PC wrap
      step(0, 1, mem(m_pc), 0, 0, 0, 0);
      chk("t6_addr", last_addr, 32'hFFFF_FFFC);
      chk("t6_npc", last_npc, 32'h0);
      step(0, 1, mem(m_pc), 0, 0, 0, 0);
      chk("t6_wrap_addr", last_addr, 32'h0);
      // Halt while waiting on ihit
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t5_req_held", {31'd0, last_ren}, 32'd1);
      step(0, 1, mem(32'h4), 0, 0, 0, 0);
      chk("t5_discard", {31'd0, last_wen}, 32'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 32'h300, 0);
      chk("t5_ren_off", {31'd0, last_ren}, 32'd0);
      chk("t5_pc_frozen", pc_o, 32'h4);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t5_pc_init", pc_o, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = (($urandom % 100) == 0) || (m_halted && (($urandom % 4) == 0));
         step(r, ($urandom % 3) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 8) == 0,
              $urandom, ($urandom % 50) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
